// File: rtl/agc_pkg.sv
// Shared widths, channel index type and saturation helper for the AGC EMA scheduler.
package agc_pkg;
   localparam int unsigned SW      = 27;
   localparam int unsigned BW      = 18;
   localparam int unsigned PW      = 45;
   localparam int unsigned FRAC    = 17;
   localparam int unsigned DP_LAT  = 4;
   localparam int unsigned NCH_DEF = 4;

   typedef logic [$clog2(NCH_DEF)-1:0] ch_t;

   // Clamp an SW+1 bit sum into the SW bit signed range.
   function automatic logic signed [SW-1:0] sat_sw(input logic signed [SW:0] v);
      logic signed [SW-1:0] r;
      if (v[SW] != v[SW-1])
         r = v[SW] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
      else
         r = v[SW-1:0];
      return r;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins; pointer moves past the winner.
module rr_arbiter #(
   parameter int unsigned NCH = 4
) (
   input  logic [NCH-1:0]         req,
   input  logic [$clog2(NCH)-1:0] ptr,
   output logic [NCH-1:0]         gnt,
   output logic [$clog2(NCH)-1:0] gnt_idx,
   output logic [$clog2(NCH)-1:0] nxt_ptr
);
   localparam int unsigned CW = $clog2(NCH);

   logic        found;
   int unsigned k;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      nxt_ptr = ptr;
      found   = 1'b0;
      k       = 0;
      for (int unsigned i = 0; i < NCH; i++) begin
         k = 32'(ptr) + i;
         if (k >= NCH) k = k - NCH;
         if (!found && req[CW'(k)]) begin
            found          = 1'b1;
            gnt[CW'(k)]    = 1'b1;
            gnt_idx        = CW'(k);
            nxt_ptr        = (k == NCH - 1) ? '0 : CW'(k + 1);
         end
      end
   end
endmodule

// File: rtl/agc_ema_scheduler.sv
// Shares one EMA multiply pipeline across NCH channels: y += alpha*(x - y), round-robin issue.
module agc_ema_scheduler
   import agc_pkg::*;
#(
   parameter int unsigned NCH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NCH-1:0]         req_valid,
   output logic [NCH-1:0]         req_ready,
   input  logic [NCH*SW-1:0]      req_sample,
   input  logic [NCH*BW-1:0]      cfg_alpha,
   input  logic                   cfg_clear,
   output logic [SW-1:0]          dp_d,
   output logic [SW-1:0]          dp_a,
   output logic [BW-1:0]          dp_b,
   input  logic [PW-1:0]          dp_p,
   output logic                   res_valid,
   output logic [$clog2(NCH)-1:0] res_ch,
   output logic [SW-1:0]          res_y,
   output logic                   busy
);
   localparam int unsigned CW = $clog2(NCH);

   logic signed [SW-1:0] y [NCH];
   logic [NCH-1:0]       inflight;
   logic [CW-1:0]        ptr;
   logic [DP_LAT:0]      tv;
   logic [CW-1:0]        tc [DP_LAT+1];

   logic [NCH-1:0]       elig;
   logic [NCH-1:0]       gnt;
   logic [CW-1:0]        gnt_idx;
   logic [CW-1:0]        nxt_ptr;
   logic                 gnt_any;
   logic [SW-1:0]        smp_g;
   logic [BW-1:0]        alpha_g;

   logic                 cap;
   logic [CW-1:0]        cap_ch;
   logic signed [SW:0]   p_sh;
   logic signed [SW:0]   sum;
   logic signed [SW-1:0] y_new;
   logic [NCH-1:0]       cap_mask;

   // Grants are suppressed while clearing or held in reset.
   assign elig      = req_valid & ~inflight & {NCH{~cfg_clear & rst_n}};
   assign req_ready = gnt;
   assign gnt_any   = |gnt;
   assign busy      = |inflight;

   rr_arbiter #(.NCH(NCH)) u_arb (
      .req     (elig),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .nxt_ptr (nxt_ptr)
   );

   always_comb begin
      smp_g   = req_sample[32'(gnt_idx)*SW +: SW];
      alpha_g = cfg_alpha[32'(gnt_idx)*BW +: BW];
   end

   // Capture path: floor-shifted product added to the channel state at SW+1 bits.
   assign cap    = tv[DP_LAT];
   assign cap_ch = tc[DP_LAT];

   always_comb begin
      p_sh     = (SW+1)'($signed(dp_p) >>> FRAC);
      sum      = {y[cap_ch][SW-1], y[cap_ch]} + p_sh;
      y_new    = sat_sw(sum);
      cap_mask = cap ? (NCH'(1) << cap_ch) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NCH; i++) y[i] <= '0;
         for (int unsigned i = 0; i <= DP_LAT; i++) tc[i] <= '0;
         inflight  <= '0;
         ptr       <= '0;
         tv        <= '0;
         dp_d      <= '0;
         dp_a      <= '0;
         dp_b      <= '0;
         res_valid <= 1'b0;
         res_ch    <= '0;
         res_y     <= '0;
      end else if (cfg_clear) begin
         for (int unsigned i = 0; i < NCH; i++) y[i] <= '0;
         inflight  <= '0;
         tv        <= '0;
         dp_d      <= '0;
         dp_a      <= '0;
         dp_b      <= '0;
         res_valid <= 1'b0;
      end else begin
         dp_d  <= gnt_any ? smp_g : '0;
         dp_a  <= gnt_any ? y[gnt_idx] : '0;
         dp_b  <= gnt_any ? alpha_g : '0;
         tv    <= {tv[DP_LAT-1:0], gnt_any};
         tc[0] <= gnt_idx;
         for (int unsigned i = 1; i <= DP_LAT; i++) tc[i] <= tc[i-1];
         if (gnt_any) ptr <= nxt_ptr;
         // A channel cannot be granted and captured in the same cycle, so mask order is moot.
         inflight  <= (inflight & ~cap_mask) | gnt;
         res_valid <= cap;
         if (cap) begin
            y[cap_ch] <= y_new;
            res_y     <= y_new;
            res_ch    <= cap_ch;
         end
      end
   end
endmodule

// File: tb/tb_agc_ema_scheduler.sv
// Directed bench for agc_ema_scheduler with a behavioural fixed-latency multiply datapath.
module tb_agc_ema_scheduler;
   import agc_pkg::*;

   localparam int unsigned NCH = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NCH-1:0]      req_valid;
   logic [NCH-1:0]      req_ready;
   logic [NCH*SW-1:0]   req_sample;
   logic [NCH*BW-1:0]   cfg_alpha;
   logic                cfg_clear;
   logic [SW-1:0]       dp_d;
   logic [SW-1:0]       dp_a;
   logic [BW-1:0]       dp_b;
   logic [PW-1:0]       dp_p;
   logic                res_valid;
   logic [1:0]          res_ch;
   logic [SW-1:0]       res_y;
   logic                busy;

   int nchk = 0;
   int nerr = 0;

   agc_ema_scheduler #(.NCH(NCH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_sample (req_sample),
      .cfg_alpha  (cfg_alpha),
      .cfg_clear  (cfg_clear),
      .dp_d       (dp_d),
      .dp_a       (dp_a),
      .dp_b       (dp_b),
      .dp_p       (dp_p),
      .res_valid  (res_valid),
      .res_ch     (res_ch),
      .res_y      (res_y),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Datapath: product of the dp_* values seen DP_LAT cycles earlier.
   logic [PW-1:0] pipe [DP_LAT];
   assign dp_p = pipe[DP_LAT-1];
   always @(posedge clk) begin
      pipe[0] <= PW'(longint'($signed(dp_b)) * (longint'($signed(dp_d)) - longint'($signed(dp_a))));
      for (int k = 1; k < DP_LAT; k++) pipe[k] <= pipe[k-1];
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint act, input longint exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int ch, input int x, input int alpha);
      req_sample[ch*SW +: SW] = SW'(x);
      cfg_alpha[ch*BW +: BW]  = BW'(alpha);
   endtask

   typedef struct {
      int ch;
      int x;
      int alpha;
      int y_prev;
      int y_exp;
   } vec_t;

   vec_t vt [9];
   int   seen;
   int   exp_rr [10];

   initial begin
      vt[0] = '{0, 1000,      65536,   0,         500};
      vt[1] = '{0, 1000,      65536,   500,       750};
      vt[2] = '{1, -1,        65536,   0,         -1};
      vt[3] = '{3, -67108864, -131072, 0,         67108863};
      vt[4] = '{2, -67108864, 131071,  0,         -67108352};
      vt[5] = '{3, 0,         65536,   67108863,  33554431};
      vt[6] = '{1, -1,        65536,   -1,        -1};
      vt[7] = '{0, 0,         0,       750,       750};
      vt[8] = '{2, 0,         -131072, -67108352, -67108864};
      exp_rr = '{1, 2, 4, 8, 0, 0, 1, 2, 0, 0};

      rst_n      = 1'b0;
      req_valid  = '1;
      req_sample = '0;
      cfg_alpha  = '0;
      cfg_clear  = 1'b0;
      repeat (6) tick();

      // Reset state, with requests asserted to confirm no grant leaks out.
      chk("rst_req_ready", longint'(req_ready), 0);
      chk("rst_res_valid", longint'(res_valid), 0);
      chk("rst_res_ch",    longint'(res_ch), 0);
      chk("rst_res_y",     longint'(res_y), 0);
      chk("rst_dp_d",      longint'(dp_d), 0);
      chk("rst_dp_a",      longint'(dp_a), 0);
      chk("rst_dp_b",      longint'(dp_b), 0);
      chk("rst_busy",      longint'(busy), 0);
      req_valid = '0;
      rst_n     = 1'b1;
      tick();

      // Single-channel updates with exact result latency.
      for (int i = 0; i < 9; i++) begin
         tick();
         set_ch(vt[i].ch, vt[i].x, vt[i].alpha);
         req_valid = NCH'(1) << vt[i].ch;
         #1;
         chk("vec_ready", longint'(req_ready), longint'(1) << vt[i].ch);
         tick();
         req_valid = '0;
         chk("vec_dp_d", longint'($signed(dp_d)), vt[i].x);
         chk("vec_dp_a", longint'($signed(dp_a)), vt[i].y_prev);
         chk("vec_dp_b", longint'($signed(dp_b)), vt[i].alpha);
         repeat (4) tick();
         chk("vec_early_valid", longint'(res_valid), 0);
         tick();
         chk("vec_res_valid", longint'(res_valid), 1);
         chk("vec_res_ch",    longint'(res_ch), vt[i].ch);
         chk("vec_res_y",     longint'($signed(res_y)), vt[i].y_exp);
      end

      // cfg_clear flushes an in-flight ch2 operation and zeroes the state.
      tick();
      set_ch(2, 1000, 65536);
      req_valid = 4'b0100;
      #1;
      chk("clr_hs_ready", longint'(req_ready), 4);
      tick();
      req_valid = '0;
      tick();
      tick();
      cfg_clear = 1'b1;
      req_valid = 4'b0001;
      set_ch(0, 1000, 65536);
      #1;
      chk("clr_ready_low", longint'(req_ready), 0);
      tick();
      cfg_clear = 1'b0;
      req_valid = '0;
      chk("clr_busy", longint'(busy), 0);
      chk("clr_dp_b", longint'(dp_b), 0);
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (res_valid) seen++;
         tick();
      end
      chk("clr_no_result", seen, 0);
      set_ch(2, 1000, 65536);
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      chk("clr_y2_zero", longint'($signed(dp_a)), 0);
      repeat (5) tick();
      chk("clr_post_valid", longint'(res_valid), 1);
      chk("clr_post_y", longint'($signed(res_y)), 500);

      // Asynchronous reset in the middle of a ch1 operation.
      tick();
      set_ch(1, 1000, 65536);
      req_valid = 4'b0010;
      tick();
      req_valid = '1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_dp_d",      longint'(dp_d), 0);
      chk("mrst_res_y",     longint'(res_y), 0);
      chk("mrst_res_ch",    longint'(res_ch), 0);
      chk("mrst_busy",      longint'(busy), 0);
      chk("mrst_req_ready", longint'(req_ready), 0);
      tick();
      rst_n     = 1'b1;
      req_valid = '0;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         if (res_valid) seen++;
         tick();
      end
      chk("mrst_no_result", seen, 0);

      // Round-robin with all channels requesting continuously from ptr = 0.
      for (int c = 0; c < 10; c++) begin
         if (c > 0) tick();
         if (c == 0) begin
            for (int ch = 0; ch < 4; ch++) set_ch(ch, 1000 * (ch + 1), 65536);
            req_valid = '1;
         end
         if (c == 8) req_valid = '0;
         #1;
         chk("rr_ready", longint'(req_ready), exp_rr[c]);
         if (c >= 6) begin
            chk("rr_res_valid", longint'(res_valid), 1);
            chk("rr_res_ch",    longint'(res_ch), c - 6);
            chk("rr_res_y",     longint'($signed(res_y)), 500 * (c - 5));
         end
         if (c == 7) chk("rr_regrant_dp_a", longint'($signed(dp_a)), 500);
      end
      repeat (8) tick();
      chk("rr_drain_busy", longint'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
